// File: rtl/data_cache_if.sv
// Backing-memory request/ack bus between the data cache and memory.
interface data_cache_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-through data cache, 4-word lines, no write allocate.
// Define DCACHE_STATS_EN to add saturating load hit/miss counters.
module data_cache #(
  parameter int INDEX_W     = 3,
  parameter int MEM_LAT_MAX = 15
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [31:0]  Address,
  input  logic [31:0]  Write_Data,
  output logic [31:0]  Read_data,
  output logic         Stall,
  data_cache_if.master mem,
  output logic         mem_err
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_W  = 28 - INDEX_W;
  localparam int WAIT_W =
    (MEM_LAT_MAX < 1) ? 1 : $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, REFILL, WRITE, WDONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  logic [1:0]         off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               ld;
  logic               busy;
  logic               fill_we;
  logic               fill_last;
  logic               wr_upd;
  logic               unused_addr;

  assign off  = Address[3:2];
  assign idx  = Address[4 +: INDEX_W];
  assign tag  = Address[31 -: TAG_W];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign ld   = MemRead && !MemWrite;
  assign busy = (state_q == REFILL) || (state_q == WRITE);
  assign unused_addr = ^Address[1:0];

  assign fill_we   = (state_q == REFILL) && mem.mem_ack;
  assign fill_last = fill_we && (cnt_q == 2'd3);
  assign wr_upd    = (state_q == WRITE) && mem.mem_ack && hit;
  assign mem_err   = err_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we)   data_q[idx][cnt_q] <= mem.mem_rdata;
    if (fill_last) tag_q[idx]         <= tag;
    if (wr_upd)    data_q[idx][off]   <= Write_Data;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    err_d         = err_q;
    valid_d       = valid_q;
    Stall         = 1'b0;
    Read_data     = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        wait_d = '0;
        if (MemWrite) begin
          Stall   = 1'b1;
          state_d = WRITE;
        end else if (MemRead) begin
          if (hit) begin
            Read_data = data_q[idx][off];
          end else begin
            Stall   = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        Stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {Address[31:4], cnt_q, 2'b00};
        if (mem.mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            valid_d[idx] = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      WRITE: begin
        Stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {Address[31:2], 2'b00};
        mem.mem_wdata = Write_Data;
        if (mem.mem_ack) state_d = WDONE;
      end
      WDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // per-beat ack timeout; the flag is sticky, the transfer keeps waiting
    if (busy) begin
      if (mem.mem_ack) begin
        wait_d = '0;
      end else if (wait_q >= WAIT_W'(MEM_LAT_MAX)) begin
        err_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if (!RESET) begin
      Stall     = 1'b0;
      Read_data = '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        relook_q;
  logic [31:0] hit_q, miss_q;
  logic        ld_first;

  // the lookup right after a refill is the same load, not a new one
  assign ld_first = (state_q == IDLE) && ld && !relook_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      relook_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      relook_q <= fill_last;
      if (ld_first && hit && !(&hit_q))
        hit_q <= hit_q + 32'd1;
      if (ld_first && !hit && !(&miss_q))
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 3, meaning log2 of line count (8 lines).
REQ-002 SHALL have parameter MEM_LAT_MAX, default 15, meaning ack-wait cycles before mem_err asserts.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemRead  input  1  pipeline MEM-stage load.
REQ-006 SHALL have port MemWrite  input  1  pipeline MEM-stage store.
REQ-007 SHALL have port Address  input  32  byte address; bits[1:0] ignored.
REQ-008 SHALL have port Write_Data  input  32  store data.
REQ-009 SHALL have port Read_data  output  32  load data.
REQ-010 SHALL have port Stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
REQ-011 SHALL have port mem_req  output  1  backing-memory request.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  output  32  word-aligned memory address.
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-016 SHALL have port mem_ack  input  1  one-cycle transfer completion.
REQ-017 SHALL have port mem_err  output  1  sticky ack-timeout flag.

Function
REQ-018 SHALL be direct-mapped: 2^INDEX_W lines, 4 words per line; offset=Address[3:2], index=Address[4+INDEX_W-1:4], tag=remaining upper bits; one valid bit per line.
REQ-019 SHALL implement FSM states IDLE, REFILL, WRITE, WDONE.
REQ-020 IDLE, MemRead hit: Read_data = cached word combinationally; Stall=0; zero added latency.
REQ-021 IDLE, MemRead miss: Stall=1 in the same cycle; next state REFILL.
REQ-022 REFILL: mem_req=1, mem_we=0, mem_addr = {tag,index,cnt,2'b00}, cnt counting 0..3; each mem_ack stores mem_rdata into word cnt and increments cnt; on the 4th ack, set valid and tag, then go to IDLE; Stall=1 throughout REFILL.
REQ-023 After refill, the IDLE re-lookup SHALL hit and release Stall; a load miss therefore costs (4 acks + 1) stall cycles minimum.
REQ-024 IDLE with MemWrite: Stall=1; go to WRITE (write-through, no-write-allocate).
REQ-025 WRITE: mem_req=1, mem_we=1, mem_addr=Address, mem_wdata=Write_Data; on mem_ack, update the cached word if the line hits, then go to WDONE; Stall=1 until ack.
REQ-026 WDONE: Stall=0, no request issued, store not repeated; next state IDLE.
REQ-027 MemRead and MemWrite both high SHALL be treated as a store; Read_data is don't-care.
REQ-028 mem_req, mem_addr, mem_we, and mem_wdata SHALL be held stable from assertion until mem_ack; mem_req SHALL drop in the cycle after the final ack.
REQ-029 mem_ack outside REFILL or WRITE SHALL be ignored.
REQ-030 A wait exceeding MEM_LAT_MAX cycles for any single ack SHALL set mem_err; the transfer SHALL continue waiting.
REQ-031 Read_data SHALL be 0 when no hit load is presented.

Reset
REQ-032 RESET low SHALL immediately clear all valid bits, force IDLE, zero cnt and the wait counter, and drive mem_req=0, mem_we=0, mem_err=0, Stall=0, Read_data=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted mid-REFILL SHALL abort the refill; the partially filled line SHALL stay invalid.
REQ-034 Tag and data arrays need no reset.

Configuration
REQ-035 With DCACHE_STATS_EN defined, the block SHALL add outputs hit_cnt[31:0] and miss_cnt[31:0]:
- Each counter increments once per load hit or load miss, counted in IDLE on first presentation only, not on the post-refill re-lookup.
- Counters saturate at 0xFFFFFFFF and reset to 0.
REQ-036 Without DCACHE_STATS_EN, the block SHALL have neither these ports nor the counter logic; all other behaviour is identical.

Verification
REQ-037 Reset, then load 0x100 with memory 0x100..0x10C = 11,22,33,44 and ack every 2nd cycle -> Stall high; 4 reads at 0x100, 0x104, 0x108, 0x10C; then Read_data=11, Stall low.
REQ-038 Load 0x108 right after REQ-037 -> Read_data=33 in the same cycle, Stall=0, mem_req never asserted.
REQ-039 Store 0xDEAD to 0x104 (hit) with ack after 3 cycles -> one mem write to 0x104, Stall released in WDONE; a following load of 0x104 returns 0xDEAD with no refill.
REQ-040 Store to 0x200 (miss), then load 0x200 -> store issues exactly one write with no refill; the load then triggers a 4-word refill from 0x200.
REQ-041 Assert RESET after the 2nd refill ack, release, and reload 0x100 -> full 4-ack refill restarts from 0x100; mem_req is 0 during reset.
REQ-042 Withhold mem_ack for 16 cycles in REFILL -> mem_err=1 and stays 1 after the late ack; with DCACHE_STATS_EN, hit_cnt=1 and miss_cnt=1 after REQ-037 and REQ-038.
